// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception-entry sequencer: FSM states, the
// memory address-source select codes (these must match the datapath address
// mux) and the exception cause codes.
package exception_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_WAIT = 2'd2,
    ST_LOAD = 2'd3
  } excState_t;

  localparam logic [2:0] SRC_PC     = 3'b000;
  localparam logic [2:0] SRC_ALUOUT = 3'b001;
  localparam logic [2:0] SRC_NOOP   = 3'b010;
  localparam logic [2:0] SRC_OVFL   = 3'b011;
  localparam logic [2:0] SRC_DIV0   = 3'b100;

  localparam logic [1:0] CAUSE_NOOP = 2'b00;
  localparam logic [1:0] CAUSE_OVFL = 2'b01;
  localparam logic [1:0] CAUSE_DIV0 = 2'b10;

  // Map a cause code onto the address-source select of its cause address.
  function automatic logic [2:0] causeToSrc(input logic [1:0] cause);
    logic [2:0] src;
    case (cause)
      CAUSE_NOOP: src = SRC_NOOP;
      CAUSE_OVFL: src = SRC_OVFL;
      CAUSE_DIV0: src = SRC_DIV0;
      default:    src = SRC_PC;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/exception_sequencer_priority_enc.sv
// Combinational three-request priority encoder for exception entry.
// Priority is noop > ovfl > div0; lower requests are simply not reported.
module exc_priority_enc
  import exception_sequencer_pkg::*;
(
  input  logic       noopReq,
  input  logic       ovflReq,
  input  logic       div0Req,
  output logic       anyReq,
  output logic [1:0] cause
);

  // Pick the highest-priority active request.
  always_comb begin
    anyReq = 1'b0;
    cause  = CAUSE_NOOP;
    if (noopReq) begin
      anyReq = 1'b1;
      cause  = CAUSE_NOOP;
    end else if (ovflReq) begin
      anyReq = 1'b1;
      cause  = CAUSE_OVFL;
    end else if (div0Req) begin
      anyReq = 1'b1;
      cause  = CAUSE_DIV0;
    end else begin
      anyReq = 1'b0;
      cause  = CAUSE_NOOP;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle exception-entry sequencer. Saves EPC, steers the memory address
// source to the cause address, waits MEM_LAT cycles for the handler byte and
// loads it into PC. All outputs are registered.
// Optional feature: define EXC_CAUSE_REG_EN to add the latched cause_out port.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int          MEM_LAT   = 1,
  parameter logic [31:0] PC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_noop,
  input  logic        exc_ovfl,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  src_add_mem,
  output logic        busy,
  output logic        epc_wr,
  output logic [31:0] epc_out,
  output logic        pc_wr,
  output logic [31:0] pc_out,
  output logic        done
`ifdef EXC_CAUSE_REG_EN
  ,
  output logic [1:0]  cause_out
`endif
);

  // Counter preload: WAIT lasts MEM_LAT cycles, ending on the edge where it is 0.
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  excState_t  state_r;
  logic [1:0] latCnt_r;
  logic       reqValid_s;
  logic [1:0] reqCause_s;
  logic       unusedMemBits_s;

  // Only the handler byte is meaningful; the upper data bits are deliberately dropped.
  assign unusedMemBits_s = ^mem_data_in[31:8];

  exc_priority_enc uPrio (
    .noopReq (exc_noop),
    .ovflReq (exc_ovfl),
    .div0Req (exc_div0),
    .anyReq  (reqValid_s),
    .cause   (reqCause_s)
  );

  // Sequencer FSM, latency counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      latCnt_r    <= 2'd0;
      src_add_mem <= SRC_PC;
      busy        <= 1'b0;
      epc_wr      <= 1'b0;
      pc_wr       <= 1'b0;
      done        <= 1'b0;
      epc_out     <= 32'd0;
      pc_out      <= 32'd0;
`ifdef EXC_CAUSE_REG_EN
      cause_out   <= 2'b00;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          pc_wr <= 1'b0;
          done  <= 1'b0;
          if (reqValid_s) begin
            state_r     <= ST_SAVE;
            src_add_mem <= causeToSrc(reqCause_s);
            busy        <= 1'b1;
            epc_wr      <= 1'b1;
            epc_out     <= pc_in - PC_OFFSET;
`ifdef EXC_CAUSE_REG_EN
            cause_out   <= reqCause_s;
`endif
          end else begin
            src_add_mem <= SRC_PC;
            busy        <= 1'b0;
            epc_wr      <= 1'b0;
          end
        end
        ST_SAVE: begin
          state_r  <= ST_WAIT;
          latCnt_r <= LAT_INIT;
          epc_wr   <= 1'b0;
        end
        ST_WAIT: begin
          if (latCnt_r == 2'd0) begin
            state_r <= ST_LOAD;
            pc_out  <= {24'd0, mem_data_in[7:0]};
            pc_wr   <= 1'b1;
            done    <= 1'b1;
          end else begin
            latCnt_r <= latCnt_r - 2'd1;
          end
        end
        ST_LOAD: begin
          state_r     <= ST_IDLE;
          pc_wr       <= 1'b0;
          done        <= 1'b0;
          busy        <= 1'b0;
          src_add_mem <= SRC_PC;
        end
        default: begin
          state_r     <= ST_IDLE;
          latCnt_r    <= 2'd0;
          src_add_mem <= SRC_PC;
          busy        <= 1'b0;
          epc_wr      <= 1'b0;
          pc_wr       <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer. Two instances (MEM_LAT=1 and
// MEM_LAT=3) see identical stimulus; a positional reference model predicts
// every output each cycle, and table vectors plus hand sequences cover corners.
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_noop, exc_ovfl, exc_div0;
  logic [31:0] pcIn, memData;

  logic [2:0]  src    [2];
  logic        busy   [2];
  logic        epcWr  [2];
  logic        pcWr   [2];
  logic        done   [2];
  logic [31:0] epcOut [2];
  logic [31:0] pcOut  [2];
`ifdef EXC_CAUSE_REG_EN
  logic [1:0]  causeOut [2];
`endif

  int lat [2] = '{1, 3};
  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  exception_sequencer #(.MEM_LAT(1)) dutLat1 (
    .clk(clk), .reset(reset), .exc_noop(exc_noop), .exc_ovfl(exc_ovfl),
    .exc_div0(exc_div0), .pc_in(pcIn), .mem_data_in(memData),
    .src_add_mem(src[0]), .busy(busy[0]), .epc_wr(epcWr[0]), .epc_out(epcOut[0]),
    .pc_wr(pcWr[0]), .pc_out(pcOut[0]), .done(done[0])
`ifdef EXC_CAUSE_REG_EN
    , .cause_out(causeOut[0])
`endif
  );

  exception_sequencer #(.MEM_LAT(3)) dutLat3 (
    .clk(clk), .reset(reset), .exc_noop(exc_noop), .exc_ovfl(exc_ovfl),
    .exc_div0(exc_div0), .pc_in(pcIn), .mem_data_in(memData),
    .src_add_mem(src[1]), .busy(busy[1]), .epc_wr(epcWr[1]), .epc_out(epcOut[1]),
    .pc_wr(pcWr[1]), .pc_out(pcOut[1]), .done(done[1])
`ifdef EXC_CAUSE_REG_EN
    , .cause_out(causeOut[1])
`endif
  );

  // Reference model: pos is the cycle index inside an exception sequence
  // (0 = save, 1..lat = wait, lat+1 = load), -1 when idle.
  int          pos    [2] = '{-1, -1};
  logic [1:0]  mCause [2];
  logic [31:0] mEpc   [2];
  logic [31:0] mPc    [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        pos[i]    <= -1;
        mCause[i] <= 2'd0;
        mEpc[i]   <= 32'd0;
        mPc[i]    <= 32'd0;
      end else if (pos[i] < 0) begin
        if (exc_noop || exc_ovfl || exc_div0) begin
          pos[i]    <= 0;
          mCause[i] <= exc_noop ? 2'd0 : (exc_ovfl ? 2'd1 : 2'd2);
          mEpc[i]   <= pcIn - 32'd4;
        end
      end else begin
        if (pos[i] == lat[i]) mPc[i] <= {24'd0, memData[7:0]};
        pos[i] <= (pos[i] >= lat[i] + 1) ? -1 : pos[i] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkModel();
    for (int i = 0; i < 2; i++) begin
      logic       eBusy;
      logic [2:0] eSrc;
      logic       eEpcWr, ePcWr;
      eBusy  = (pos[i] >= 0);
      eSrc   = eBusy ? (3'd2 + {1'b0, mCause[i]}) : 3'd0;
      eEpcWr = (pos[i] == 0);
      ePcWr  = (pos[i] == lat[i] + 1);
      check($sformatf("model_lat%0d", lat[i]),
            {src[i], busy[i], epcWr[i], pcWr[i], done[i], epcOut[i], pcOut[i]},
            {eSrc, eBusy, eEpcWr, ePcWr, ePcWr, mEpc[i], mPc[i]});
`ifdef EXC_CAUSE_REG_EN
      check($sformatf("model_cause_lat%0d", lat[i]), causeOut[i], mCause[i]);
`endif
    end
  endtask

  // One clock: model check on the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (checkEn) checkModel();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        noop, ovfl, div0;
    logic [31:0] pcIn, memData, expEpc, expPc;
    logic [2:0]  expSrc;
    logic [1:0]  expCause;
  } vec_t;

  vec_t vecs [6];
  int busyCnt [2], pcWrCnt [2], epcWrCnt [2], srcBad [2];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080, 32'h0000_003C, 32'h0000_0080, 3'b011, 2'b01};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'hABCD_12F0, 32'h0000_0FFC, 32'h0000_00F0, 3'b010, 2'b00};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0055, 32'h0000_01FC, 32'h0000_0055, 3'b100, 2'b10};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0001, 32'h0000_0004, 32'h0000_0001, 3'b010, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FF07, 32'hFFFF_FFFC, 32'h0000_0007, 3'b011, 2'b01};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1234_56FF, 32'hFFFF_FFFB, 32'h0000_00FF, 3'b100, 2'b10};

    reset = 1'b1; exc_noop = 1'b0; exc_ovfl = 1'b0; exc_div0 = 1'b0;
    pcIn = 32'd0; memData = 32'd0;
    tick();
    checkEn = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_outputs_lat%0d", lat[i]),
            {src[i], busy[i], epcWr[i], pcWr[i], done[i], epcOut[i], pcOut[i]}, 71'd0);
    end
    reset = 1'b0;
    tick();

    // Table-driven single-exception sequences.
    for (int v = 0; v < 6; v++) begin
      exc_noop = vecs[v].noop; exc_ovfl = vecs[v].ovfl; exc_div0 = vecs[v].div0;
      pcIn = vecs[v].pcIn; memData = vecs[v].memData;
      tick();
      exc_noop = 1'b0; exc_ovfl = 1'b0; exc_div0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        busyCnt[i] = 0; pcWrCnt[i] = 0; epcWrCnt[i] = 0; srcBad[i] = 0;
      end
      for (int c = 0; c < 10; c++) begin
        for (int i = 0; i < 2; i++) begin
          if (busy[i]) busyCnt[i]++;
          if (busy[i] && src[i] !== vecs[v].expSrc) srcBad[i]++;
          if (pcWr[i]) pcWrCnt[i]++;
          if (epcWr[i]) epcWrCnt[i]++;
        end
        tick();
      end
      for (int i = 0; i < 2; i++) begin
        check($sformatf("vec%0d_busy_cycles_lat%0d", v, lat[i]), busyCnt[i], 2 + lat[i]);
        check($sformatf("vec%0d_src_lat%0d", v, lat[i]), srcBad[i], 0);
        check($sformatf("vec%0d_pcwr_count_lat%0d", v, lat[i]), pcWrCnt[i], 1);
        check($sformatf("vec%0d_epcwr_count_lat%0d", v, lat[i]), epcWrCnt[i], 1);
        check($sformatf("vec%0d_epc_lat%0d", v, lat[i]), epcOut[i], vecs[v].expEpc);
        check($sformatf("vec%0d_pc_lat%0d", v, lat[i]), pcOut[i], vecs[v].expPc);
`ifdef EXC_CAUSE_REG_EN
        check($sformatf("vec%0d_cause_lat%0d", v, lat[i]), causeOut[i], vecs[v].expCause);
`endif
      end
    end

    // Handler byte must come from the data present on the last wait edge.
    pcIn = 32'h0000_0100; memData = 32'h0000_00EE; exc_div0 = 1'b1;
    tick();
    exc_div0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      memData = 32'h10 + 32'(k);
      tick();
    end
    check("data_window_pc_lat1", pcOut[0], 32'h0000_0011);
    check("data_window_pc_lat3", pcOut[1], 32'h0000_0013);
    check("data_window_epc_lat3", epcOut[1], 32'h0000_00FC);

    // A request re-pulsed mid-sequence is ignored.
    exc_ovfl = 1'b1;
    tick();
    exc_ovfl = 1'b0;
    tick();
    exc_ovfl = 1'b1;
    tick();
    exc_ovfl = 1'b0;
    pcWrCnt[0] = 0; pcWrCnt[1] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 2; i++) if (pcWr[i]) pcWrCnt[i]++;
      tick();
    end
    check("repulse_pcwr_count_lat1", pcWrCnt[0], 1);
    check("repulse_pcwr_count_lat3", pcWrCnt[1], 1);

    // Reset during wait aborts the sequence with no PC write.
    exc_div0 = 1'b1;
    tick();
    exc_div0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_state_lat%0d", lat[i]), {busy[i], src[i], pcWr[i]}, 5'd0);
    end
    reset = 1'b0;
    pcWrCnt[0] = 0; pcWrCnt[1] = 0; epcWrCnt[0] = 0; epcWrCnt[1] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (pcWr[i]) pcWrCnt[i]++;
        if (epcWr[i]) epcWrCnt[i]++;
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_no_strobes_lat%0d", lat[i]), pcWrCnt[i] + epcWrCnt[i], 0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1) begin
        exc_noop = r[2]; exc_ovfl = r[1]; exc_div0 = r[0];
      end else begin
        exc_noop = 1'b0; exc_ovfl = 1'b0; exc_div0 = 1'b0;
      end
      pcIn = $urandom;
      memData = $urandom;
      tick();
    end
    reset = 1'b0; exc_noop = 1'b0; exc_ovfl = 1'b0; exc_div0 = 1'b0;
    for (int c = 0; c < 6; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
